// File: rtl/register_file_sb.sv
// Decode-stage register file: three combinational read ports with optional write
// forwarding, one write-back port, PC held in the top register, pending-write scoreboard.
module register_file_sb #(
  parameter  int WIDTH  = 32,
  parameter  int NREG   = 16,
  localparam int IW     = $clog2(NREG),
  parameter  int PC_INC = 4,
  parameter  int BYPASS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IW-1:0]    SA,
  input  logic [IW-1:0]    SB,
  input  logic [IW-1:0]    SD,
  output logic [WIDTH-1:0] PA,
  output logic [WIDTH-1:0] PB,
  output logic [WIDTH-1:0] PD,
  input  logic [IW-1:0]    C,
  input  logic [WIDTH-1:0] PW,
  input  logic             RFLd,
  input  logic [WIDTH-1:0] PCin,
  input  logic             PCLd,
  input  logic             PCInc,
  output logic [WIDTH-1:0] PCout,
  input  logic             IssLd,
  input  logic [IW-1:0]    IssC,
  output logic             BusyA,
  output logic             BusyB,
  output logic             BusyD
);

  localparam logic [IW-1:0] PC_IDX = IW'(NREG - 1);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic             wr_pc;
  logic             fwd_a, fwd_b, fwd_d;

  assign wr_pc = RFLd && (C == PC_IDX);

  // A new issue to the same index as a retiring write leaves the register pending.
  always_comb begin
    pending_nxt = pending;
    if (RFLd)  pending_nxt[C]    = 1'b0;
    if (IssLd) pending_nxt[IssC] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (RFLd) regs[C] <= PW;
      if (!wr_pc) begin
        if (PCLd)       regs[PC_IDX] <= PCin;
        else if (PCInc) regs[PC_IDX] <= regs[PC_IDX] + WIDTH'(PC_INC);
      end
      pending <= pending_nxt;
    end
  end

  assign fwd_a = (BYPASS != 0) && RFLd && (C == SA);
  assign fwd_b = (BYPASS != 0) && RFLd && (C == SB);
  assign fwd_d = (BYPASS != 0) && RFLd && (C == SD);

  assign PA = fwd_a ? PW : regs[SA];
  assign PB = fwd_b ? PW : regs[SB];
  assign PD = fwd_d ? PW : regs[SD];

  // A forwarded operand is already available, so it does not stall.
  assign BusyA = pending[SA] && !fwd_a;
  assign BusyB = pending[SB] && !fwd_b;
  assign BusyD = pending[SD] && !fwd_d;

  assign PCout = regs[PC_IDX];

endmodule
